// File: rtl/tinynpu_pkg.sv
// rtl/tinynpu_pkg.sv - state encodings shared by the tinynpu scheduler
package tinynpu_pkg;

    localparam int TRACE_W = 3;

    typedef enum logic [TRACE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_WLOAD = 3'd1,
        ST_XLOAD = 3'd2,
        ST_MAC   = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DRAIN = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

endpackage

// File: rtl/tinynpu_sched_obuf.sv
// rtl/tinynpu_sched_obuf.sv - one-entry result buffer with NPU read in-flight tracking
module tinynpu_sched_obuf #(
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue,
    input  logic [NBITS-1:0] z_in,
    input  logic             z_rdy,
    output logic [NBITS-1:0] z_data,
    output logic             z_val,
    output logic             capture,
    output logic             issue_ok
);

    logic             inflight;
    logic             full;
    logic [NBITS-1:0] data;
    logic             pop;

    assign pop      = full & z_rdy;
    assign capture  = inflight;
    // A new read may start only if its result will find the buffer empty.
    assign issue_ok = ~inflight & (~full | pop);
    assign z_val    = full;
    assign z_data   = data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= 1'b0;
            full     <= 1'b0;
            data     <= '0;
        end else begin
            inflight <= issue;
            if (inflight) begin
                full <= 1'b1;
                data <= z_in;
            end else if (pop) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tinynpu_sched.sv
// rtl/tinynpu_sched.sv - job scheduler sequencing weight/x loads, MAC and result drain for the NPU
module tinynpu_sched
    import tinynpu_pkg::*;
#(
    parameter int SIZE     = 4,
    parameter int NBITS    = 8,
    parameter int MAC_WAIT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_val,
    output logic                    cmd_rdy,
    input  logic [7:0]              cmd_nvec,
    input  logic                    cmd_wreuse,
    input  logic [NBITS-1:0]        in_data,
    input  logic                    in_val,
    output logic                    in_rdy,
    output logic [NBITS-1:0]        z_data,
    output logic                    z_val,
    input  logic                    z_rdy,
    output logic [NBITS-1:0]        npu_x_in,
    output logic [NBITS-1:0]        npu_w_in,
    output logic                    npu_x_load_val,
    output logic                    npu_w_load_val,
    output logic                    npu_mac_val,
    output logic                    npu_out_val,
    output logic [$clog2(SIZE)-1:0] npu_w_load_sel,
    input  logic [NBITS-1:0]        npu_z_out,
    output logic                    busy,
    output logic                    done,
    output logic [TRACE_W-1:0]      trace_state
);

    localparam int LOG_S = $clog2(SIZE);
    localparam int WW    = $clog2(SIZE * SIZE) + 1;
    localparam int WTW   = $clog2(MAC_WAIT + 1);
    localparam logic [WW-1:0]  W_LAST = WW'(SIZE * SIZE - 1);
    localparam logic [WW-1:0]  X_LAST = WW'(SIZE - 1);
    localparam logic [WW-1:0]  N_OUT  = WW'(SIZE);
    localparam logic [WTW-1:0] T_LAST = WTW'(MAC_WAIT - 1);

    state_t         state, state_next;
    logic [WW-1:0]  word_cnt;
    logic [WTW-1:0] wait_cnt;
    logic [7:0]     vec_cnt;
    logic           issue, issue_ok, capture, beat, last_cap;

    tinynpu_sched_obuf #(.NBITS(NBITS)) u_obuf (
        .clk      (clk),
        .rst      (rst),
        .issue    (issue),
        .z_in     (npu_z_out),
        .z_rdy    (z_rdy),
        .z_data   (z_data),
        .z_val    (z_val),
        .capture  (capture),
        .issue_ok (issue_ok)
    );

    always_comb begin
        state_next     = state;
        cmd_rdy        = 1'b0;
        in_rdy         = 1'b0;
        npu_w_load_val = 1'b0;
        npu_x_load_val = 1'b0;
        npu_mac_val    = 1'b0;
        npu_w_in       = '0;
        npu_x_in       = '0;
        npu_w_load_sel = '0;
        issue          = 1'b0;
        last_cap       = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_rdy = 1'b1;
                if (cmd_val) begin
                    if (!cmd_wreuse)
                        state_next = ST_WLOAD;
                    else if (cmd_nvec == 8'd0)
                        state_next = ST_DONE;
                    else
                        state_next = ST_XLOAD;
                end
            end
            ST_WLOAD: begin
                in_rdy         = 1'b1;
                npu_w_load_sel = word_cnt[2*LOG_S-1:LOG_S];
                if (in_val) begin
                    npu_w_load_val = 1'b1;
                    npu_w_in       = in_data;
                    if (word_cnt == W_LAST)
                        state_next = (vec_cnt == 8'd0) ? ST_DONE : ST_XLOAD;
                end
            end
            ST_XLOAD: begin
                in_rdy = 1'b1;
                if (in_val) begin
                    npu_x_load_val = 1'b1;
                    npu_x_in       = in_data;
                    if (word_cnt == X_LAST)
                        state_next = ST_MAC;
                end
            end
            ST_MAC: begin
                npu_mac_val = 1'b1;
                state_next  = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt == T_LAST)
                    state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                issue = (word_cnt != N_OUT) && issue_ok;
                // The last vector waits here until its final result leaves the buffer.
                if (capture && word_cnt == N_OUT) begin
                    last_cap = 1'b1;
                    if (vec_cnt != 8'd1)
                        state_next = ST_XLOAD;
                end else if (vec_cnt == 8'd0 && !z_val) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign beat        = npu_w_load_val | npu_x_load_val | issue;
    assign npu_out_val = issue;
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);
    assign trace_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            word_cnt <= '0;
            wait_cnt <= '0;
            vec_cnt  <= '0;
        end else begin
            state <= state_next;
            if (state_next != state)
                word_cnt <= '0;
            else if (beat)
                word_cnt <= word_cnt + WW'(1);
            if (state == ST_WAIT && state_next == ST_WAIT)
                wait_cnt <= wait_cnt + WTW'(1);
            else
                wait_cnt <= '0;
            if (state == ST_IDLE && cmd_val)
                vec_cnt <= cmd_nvec;
            else if (last_cap)
                vec_cnt <= vec_cnt - 8'd1;
        end
    end

endmodule

// File: tb/tb_tinynpu_sched.sv
// tb/tb_tinynpu_sched.sv - scoreboard bench for the tinynpu scheduler
module tb_tinynpu_sched;

    localparam int SIZE     = 4;
    localparam int NBITS    = 8;
    localparam int MAC_WAIT = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cmd_val = 1'b0;
    logic             cmd_rdy;
    logic [7:0]       cmd_nvec = 8'd0;
    logic             cmd_wreuse = 1'b0;
    logic [NBITS-1:0] in_data = '0;
    logic             in_val = 1'b0;
    logic             in_rdy;
    logic [NBITS-1:0] z_data;
    logic             z_val;
    logic             z_rdy = 1'b1;
    logic [NBITS-1:0] npu_x_in, npu_w_in;
    logic             npu_x_load_val, npu_w_load_val, npu_mac_val, npu_out_val;
    logic [1:0]       npu_w_load_sel;
    logic [NBITS-1:0] npu_z_out = '0;
    logic             busy, done;
    logic [2:0]       trace_state;

    tinynpu_sched #(.SIZE(SIZE), .NBITS(NBITS), .MAC_WAIT(MAC_WAIT)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_val        (cmd_val),
        .cmd_rdy        (cmd_rdy),
        .cmd_nvec       (cmd_nvec),
        .cmd_wreuse     (cmd_wreuse),
        .in_data        (in_data),
        .in_val         (in_val),
        .in_rdy         (in_rdy),
        .z_data         (z_data),
        .z_val          (z_val),
        .z_rdy          (z_rdy),
        .npu_x_in       (npu_x_in),
        .npu_w_in       (npu_w_in),
        .npu_x_load_val (npu_x_load_val),
        .npu_w_load_val (npu_w_load_val),
        .npu_mac_val    (npu_mac_val),
        .npu_out_val    (npu_out_val),
        .npu_w_load_sel (npu_w_load_sel),
        .npu_z_out      (npu_z_out),
        .busy           (busy),
        .done           (done),
        .trace_state    (trace_state)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0, n_w = 0, n_x = 0, n_mac = 0, n_done = 0, n_z = 0, nz = 0;
    int mac_cyc = 0, exp_idx = 0, xs = 0, zmode = 0, zph = 0;
    bit pend = 0, pv = 0, pr = 0;
    logic [7:0] pd = '0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // NPU stand-in: result appears only in the cycle after out_val, garbage otherwise
    initial begin
        bit ov;
        forever begin
            @(negedge clk);
            ov = npu_out_val;
            @(posedge clk);
            #1;
            npu_z_out = ov ? 8'(64 + nz) : 8'hEE;
            if (ov) nz++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            zph   = (zph + 1) % 4;
            z_rdy = (zmode == 0) ? 1'b1 : (zph == 0 || zph == 3);
        end
    end

    // Monitor / scoreboard
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                pend = 0;
                pv   = 0;
            end else begin
                if (npu_w_load_val) begin
                    check("w_sel", npu_w_load_sel, (n_w % 16) / 4);
                    check("w_data", npu_w_in, (n_w % 16) + 1);
                    n_w++;
                end
                if (npu_x_load_val) begin
                    check("x_data", npu_x_in, 128 + (n_x % 128));
                    n_x++;
                end
                if ((trace_state == 3'd1 || trace_state == 3'd2) && !in_val)
                    check("gap_strobe", {npu_w_load_val, npu_x_load_val}, 0);
                if (trace_state != 3'd1 && trace_state != 3'd2)
                    check("in_rdy_off", in_rdy, 0);
                if (npu_mac_val) begin
                    n_mac++;
                    mac_cyc = cyc;
                    pend    = 1;
                end
                if (npu_out_val && pend) begin
                    check("mac_to_out", cyc - mac_cyc, MAC_WAIT + 1);
                    pend = 0;
                end
                if (done) n_done++;
                if (pv && !pr) check("z_hold", {z_val, z_data}, {1'b1, pd});
                if (z_val && z_rdy) begin
                    check("z_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("z_data", z_data, e);
                    end
                    n_z++;
                end
                pv = z_val;
                pr = z_rdy;
                pd = z_data;
            end
        end
    end

    task automatic send_cmd(input int n, input bit w);
        int t = 0;
        cmd_nvec   = 8'(n);
        cmd_wreuse = w;
        while (t < 500) begin
            @(negedge clk);
            if (cmd_rdy) break;
            t++;
        end
        check("cmd_rdy_wait", cmd_rdy, 1);
        cmd_val = 1'b1;
        @(posedge clk);
        #1;
        cmd_val = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] d, input int gap);
        int t = 0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_val  = 1'b1;
        in_data = d;
        while (t < 500) begin
            @(negedge clk);
            if (in_rdy) break;
            t++;
        end
        check("in_rdy_wait", in_rdy, 1);
        @(posedge clk);
        #1;
        in_val = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (t < 2000) begin
            @(negedge clk);
            #1;
            if (done) break;
            t++;
        end
        check("done_seen", done, 1);
    endtask

    task automatic load_job(input int n, input bit w, input int wgap);
        send_cmd(n, w);
        if (!w)
            for (int k = 0; k < 16; k++) send_word(8'(k + 1), wgap);
        for (int v = 0; v < n; v++) begin
            for (int i = 0; i < SIZE; i++) begin
                exp_q.push_back(8'(64 + exp_idx));
                exp_idx++;
            end
            for (int i = 0; i < SIZE; i++) begin
                send_word(8'(128 + (xs % 128)), 0);
                xs++;
            end
        end
    endtask

    task automatic run_job(input int n, input bit w, input int wgap);
        int w0, m0, d0, z0;
        w0 = n_w; m0 = n_mac; d0 = n_done; z0 = n_z;
        load_job(n, w, wgap);
        wait_done();
        @(negedge clk);
        #1;
        check("done_1cyc", done, 0);
        check("cmd_rdy_after", cmd_rdy, 1);
        check("w_beats", n_w - w0, w ? 0 : 16);
        check("mac_pulses", n_mac - m0, n);
        check("z_beats", n_z - z0, SIZE * n);
        check("done_pulses", n_done - d0, 1);
        check("q_empty", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        repeat (3) @(negedge clk);
        #1;
        check("rst_cmd_rdy", cmd_rdy, 1);
        check("rst_outs", {busy, done, z_val, in_rdy, npu_w_load_val, npu_x_load_val,
                           npu_mac_val, npu_out_val}, 0);
        check("rst_trace", trace_state, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        zmode = 0;
        run_job(1, 1'b0, 0);
        run_job(3, 1'b1, 0);
        zmode = 1;
        run_job(2, 1'b1, 0);
        zmode = 0;
        run_job(1, 1'b0, 2);
        run_job(0, 1'b0, 0);

        @(posedge clk);
        #1;
        cmd_nvec   = 8'd0;
        cmd_wreuse = 1'b1;
        cmd_val    = 1'b1;
        @(negedge clk);
        check("reuse0_idle", trace_state, 0);
        @(posedge clk);
        #1;
        cmd_val = 1'b0;
        @(negedge clk);
        check("reuse0_done_state", trace_state, 6);
        check("reuse0_done", done, 1);
        @(negedge clk);
        check("reuse0_back_idle", trace_state, 0);
        check("reuse0_cmd_rdy", cmd_rdy, 1);

        load_job(1, 1'b0, 0);
        t = 0;
        while (t < 100) begin
            @(negedge clk);
            if (trace_state == 3'd4) break;
            t++;
        end
        check("reach_wait", trace_state, 4);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cmd_rdy", cmd_rdy, 1);
        check("mid_rst_strobes", {npu_w_load_val, npu_x_load_val, npu_mac_val, npu_out_val,
                                  done, z_val}, 0);
        check("mid_rst_trace", trace_state, 0);
        exp_q.delete();
        exp_idx = nz;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_job(1, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
